dense_layer_seq: RTL and testbench

- Sequential fully-connected stage directly downstream of the conv/ReLU/maxpool layer.
- Consumes the flattened pooled feature vector (32×13×13 = 5408 words) as one flat bus, plus a flat weight bus and a flat bias bus.
- Computes one signed MAC per clock, adds bias, optionally applies ReLU, and presents per-class scores (24 static hand-sign letters) on a flat result bus.
- Uses a valid/ready handshake on both input and output.

---
 rtl/dense_pkg.sv | 23 ++
 rtl/dense_mac.sv | 49 ++++
 rtl/dense_layer_seq.sv | 168 ++++++++++++++++
 tb/tb_dense_layer_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// ============================================================================
// dense_pkg : FSM state encoding and accumulator-width helper for dense layer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package dense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_BIAS = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Wide enough for IN_LEN full-scale products plus a sign-extended bias.
  function automatic int acc_width(input int ibw, input int wbw, input int in_len);
    return ibw + wbw + $clog2(in_len) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dense_mac.sv
// ============================================================================
// dense_mac : registered signed multiply-accumulate with sync clear and enable
// Revision  : 1.0
// ============================================================================
`default_nettype none

module dense_mac #(
  parameter int IBW = 16,
  parameter int WBW = 16,
  parameter int ABW = 46
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic signed [IBW-1:0] a_i,
  input  logic signed [WBW-1:0] b_i,
  output logic signed [ABW-1:0] acc_o
);

  localparam int PW = IBW + WBW;

  logic signed [PW-1:0]  w_a_ext;
  logic signed [PW-1:0]  w_b_ext;
  logic signed [PW-1:0]  w_prod;
  logic signed [ABW-1:0] w_prod_ext;
  logic signed [ABW-1:0] acc_q;

  // Operands widened first so the low PW bits of the product are exact.
  assign w_a_ext    = {{WBW{a_i[IBW-1]}}, a_i};
  assign w_b_ext    = {{IBW{b_i[WBW-1]}}, b_i};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ABW-PW){w_prod[PW-1]}}, w_prod};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + w_prod_ext;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/dense_layer_seq.sv
// ============================================================================
// dense_layer_seq : sequential fully-connected layer, one MAC per clock,
//                   optional ReLU on outputs when DENSE_RELU_EN is defined
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int IBW     = 16,
  parameter int WBW     = 16,
  parameter int IN_LEN  = 5408,
  parameter int NEURONS = 24,
  parameter int CW      = $clog2(IN_LEN),
  parameter int ABW     = acc_width(IBW, WBW, IN_LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IBW*IN_LEN-1:0]       data,
  input  logic [WBW*IN_LEN*NEURONS-1:0] weights,
  input  logic [WBW*NEURONS-1:0]      bias,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ABW*NEURONS-1:0]      result,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int JW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   n_q, n_d;
  logic [JW-1:0]   j_q, j_d;
  logic            out_valid_q, out_valid_d;
  logic            w_load, w_mac_en, w_bias_we;

  logic signed [IBW-1:0] data_q   [IN_LEN];
  logic signed [WBW-1:0] w_q      [NEURONS][IN_LEN];
  logic signed [WBW-1:0] bias_q   [NEURONS];
  logic signed [ABW-1:0] result_q [NEURONS];

  logic signed [ABW-1:0] w_acc;
  logic signed [WBW-1:0] w_bias_sel;
  logic signed [ABW-1:0] w_sum;
  logic signed [ABW-1:0] w_res;

  // Operand snapshot taken on accept; input buses are ignored afterwards.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int n = 0; n < IN_LEN; n++) begin
        data_q[n] <= data[n*IBW +: IBW];
      end
      for (int j = 0; j < NEURONS; j++) begin
        bias_q[j] <= bias[j*WBW +: WBW];
        for (int n = 0; n < IN_LEN; n++) begin
          w_q[j][n] <= weights[(j*IN_LEN+n)*WBW +: WBW];
        end
      end
    end
  end

  dense_mac #(
    .IBW (IBW),
    .WBW (WBW),
    .ABW (ABW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (w_load | w_bias_we),
    .en_i  (w_mac_en),
    .a_i   (data_q[n_q]),
    .b_i   (w_q[j_q][n_q]),
    .acc_o (w_acc)
  );

  assign w_bias_sel = bias_q[j_q];
  assign w_sum      = w_acc + {{(ABW-WBW){w_bias_sel[WBW-1]}}, w_bias_sel};

`ifdef DENSE_RELU_EN
  assign w_res = w_sum[ABW-1] ? '0 : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NEURONS; j++) begin
        result_q[j] <= '0;
      end
    end else if (w_bias_we) begin
      result_q[j_q] <= w_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      j_q         <= j_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    j_d         = j_q;
    out_valid_d = out_valid_q;
    w_load      = 1'b0;
    w_mac_en    = 1'b0;
    w_bias_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          w_load  = 1'b1;
          n_d     = '0;
          j_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        w_mac_en = 1'b1;
        if (n_q == CW'(IN_LEN-1)) begin
          state_d = ST_BIAS;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      ST_BIAS: begin
        w_bias_we = 1'b1;
        n_d       = '0;
        if (j_q == JW'(NEURONS-1)) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        // out_valid rises one cycle after entering DONE, then waits for ready.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  generate
    for (genvar j = 0; j < NEURONS; j++) begin : g_result
      assign result[j*ABW +: ABW] = result_q[j];
    end
  endgenerate

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dense_layer_seq.sv
// ============================================================================
// tb_dense_layer_seq : directed vector bench for dense_layer_seq (4 in, 3 out)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_dense_layer_seq;

  localparam int IBW     = 8;
  localparam int WBW     = 8;
  localparam int IN_LEN  = 4;
  localparam int NEURONS = 3;
  localparam int CW      = 2;
  localparam int ABW     = 19;
  localparam int LAT     = NEURONS*(IN_LEN+1)+1;

  logic                     clk;
  logic                     rst_n;
  logic [31:0]              data;
  logic [95:0]              weights;
  logic [23:0]              bias;
  logic                     in_valid;
  logic                     in_ready;
  logic [56:0]              result;
  logic                     out_valid;
  logic                     out_ready;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic [31:0] d;
    logic [95:0] w;
    logic [23:0] b;
    logic [56:0] e;
    logic [56:0] er;
  } vec_t;

  vec_t vecs [4];

  dense_layer_seq #(
    .IBW     (IBW),
    .WBW     (WBW),
    .IN_LEN  (IN_LEN),
    .NEURONS (NEURONS),
    .CW      (CW),
    .ABW     (ABW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .weights   (weights),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [23:0] pkb(input int a, input int b, input int c);
    return {c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [56:0] pke(input int a, input int b, input int c);
    return {c[18:0], b[18:0], a[18:0]};
  endfunction

  function automatic logic [56:0] exp_of(input vec_t v);
`ifdef DENSE_RELU_EN
    return v.er;
`else
    return v.e;
`endif
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present a vector, take the accept edge, then scramble the buses.
  task automatic start(input vec_t v);
    int k;
    k = 0;
    data = v.d; weights = v.w; bias = v.b; in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("in_ready_pre_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    data = ~v.d; weights = ~v.w; bias = ~v.b;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid", 64'(out_valid), 64'd0);
    check("hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data = '0; weights = '0; bias = '0;

    vecs[0].d  = pk4(1, 2, 3, 4);
    vecs[0].w  = {pk4(-1, -1, -1, -1), pk4(2, 0, 0, 0), pk4(1, 1, 1, 1)};
    vecs[0].b  = pkb(0, 5, 0);
    vecs[0].e  = pke(10, 7, -10);
    vecs[0].er = pke(10, 7, 0);

    vecs[1].d  = pk4(-128, -128, -128, -128);
    vecs[1].w  = {pk4(-128, -128, -128, -128), pk4(-128, -128, -128, -128), pk4(-128, -128, -128, -128)};
    vecs[1].b  = pkb(127, 127, 127);
    vecs[1].e  = pke(65663, 65663, 65663);
    vecs[1].er = pke(65663, 65663, 65663);

    vecs[2].d  = pk4(-3, 5, 0, 7);
    vecs[2].w  = {pk4(127, 127, 127, 127), pk4(0, 0, 0, -2), pk4(2, -1, 4, 1)};
    vecs[2].b  = pkb(10, -1, -128);
    vecs[2].e  = pke(6, -15, 1015);
    vecs[2].er = pke(6, 0, 1015);

    vecs[3].d  = pk4(127, 127, 127, 127);
    vecs[3].w  = {pk4(0, 0, 0, 0), pk4(-128, -128, -128, -128), pk4(127, 127, 127, 127)};
    vecs[3].b  = pkb(127, -128, -7);
    vecs[3].e  = pke(64643, -65152, -7);
    vecs[3].er = pke(64643, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      start(vecs[i]);
      wait_done(lat);
      check($sformatf("latency_v%0d", i), 64'(lat), 64'(LAT));
      check($sformatf("result_v%0d", i), 64'(result), 64'(exp_of(vecs[i])));
      handshake();
    end

    // Backpressure: result and flags frozen, new input refused.
    start(vecs[0]);
    wait_done(lat);
    data = vecs[1].d; weights = vecs[1].w; bias = vecs[1].b; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result", 64'(result), 64'(exp_of(vecs[0])));
    end
    in_valid = 1'b0;
    handshake();

    // Reset during neuron 1 discards everything.
    start(vecs[2]);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    start(vecs[3]);
    wait_done(lat);
    check("postrst_latency", 64'(lat), 64'(LAT));
    check("postrst_result", 64'(result), 64'(exp_of(vecs[3])));
    handshake();

    // Back-to-back: second vector waits with in_valid held high.
    data = vecs[0].d; weights = vecs[0].w; bias = vecs[0].b; in_valid = 1'b1;
    @(posedge clk); #1;
    data = vecs[2].d; weights = vecs[2].w; bias = vecs[2].b;
    wait_done(lat);
    check("b2b_first_latency", 64'(lat), 64'(LAT));
    check("b2b_first_result", 64'(result), 64'(exp_of(vecs[0])));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("b2b_second_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    data = '0; weights = '0; bias = '0;
    wait_done(lat);
    check("b2b_second_latency", 64'(lat), 64'(LAT));
    check("b2b_second_result", 64'(result), 64'(exp_of(vecs[2])));
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
